pattern_rotator: RTL and testbench

PATTERN_ROTATOR -- requirements
Module: pattern_rotator

---
 rtl/pattern_rotator.sv | 63 ++++++
 tb/tb_pattern_rotator.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_rotator.sv
// Rotating / shifting pattern ring with a step-position counter,
// wrap pulse and a display-blanking output stage.
module pattern_rotator #(
    parameter int WIDTH = 13,
    parameter logic [WIDTH-1:0] INIT = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int PW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             ser_in,
    input  logic             disp_en,
    output logic [WIDTH-1:0] pat,
    output logic [WIDTH-1:0] pat_n,
    output logic [PW-1:0]    pos,
    output logic             wrap
);

    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_step;
    logic [PW-1:0]    pos_step;
    logic             fill;

    always_comb begin
        fill = mode ? ser_in : (dir ? sr[0] : sr[WIDTH-1]);
        if (dir) begin
            sr_step  = {fill, sr[WIDTH-1:1]};
            pos_step = (pos == '0) ? POS_MAX : pos - PW'(1);
        end else begin
            sr_step  = {sr[WIDTH-2:0], fill};
            pos_step = (pos == POS_MAX) ? '0 : pos + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= INIT;
            pos  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            sr   <= load_data;
            pos  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            sr   <= sr_step;
            pos  <= pos_step;
            // Only a step that arrives at 0 from elsewhere counts as a wrap
            wrap <= (pos != '0) && (pos_step == '0);
        end else begin
            wrap <= 1'b0;
        end
    end

    assign pat   = disp_en ? sr : '1;
    assign pat_n = disp_en ? ~sr : '1;

endmodule

// File: tb/tb_pattern_rotator.sv
// Scoreboard bench for pattern_rotator (WIDTH=13, INIT=1).
// Expected results are queued as stimulus is driven and popped after each edge.
module tb_pattern_rotator;

    localparam int W = 13;

    typedef struct packed {
        logic [W-1:0] pat;
        logic [W-1:0] pat_n;
        logic [3:0]   pos;
        logic         wrap;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         en = 1'b0;
    logic         dir = 1'b0;
    logic         mode = 1'b0;
    logic         ser_in = 1'b0;
    logic         disp_en = 1'b1;
    logic [W-1:0] pat;
    logic [W-1:0] pat_n;
    logic [3:0]   pos;
    logic         wrap;

    int total = 0;
    int bad = 0;

    exp_t sbq[$];
    logic [W-1:0] m_sr;
    int           m_pos;
    logic         m_wrap;

    pattern_rotator dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_data(load_data),
        .en(en),
        .dir(dir),
        .mode(mode),
        .ser_in(ser_in),
        .disp_en(disp_en),
        .pat(pat),
        .pat_n(pat_n),
        .pos(pos),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        e.pat   = disp_en ? m_sr : 13'h1fff;
        e.pat_n = disp_en ? ~m_sr : 13'h1fff;
        e.pos   = 4'(m_pos);
        e.wrap  = m_wrap;
        return e;
    endfunction

    // Advance the model for the current inputs, queue the result, clock the DUT.
    task automatic cycle();
        logic [W-1:0] nsr;
        int old_pos;
        if (load) begin
            m_sr = load_data;
            m_pos = 0;
            m_wrap = 1'b0;
        end else if (en) begin
            nsr = m_sr;
            if (!dir) begin
                for (int i = 1; i < W; i++) nsr[i] = m_sr[i-1];
                nsr[0] = mode ? ser_in : m_sr[W-1];
            end else begin
                for (int i = 0; i < W - 1; i++) nsr[i] = m_sr[i+1];
                nsr[W-1] = mode ? ser_in : m_sr[0];
            end
            m_sr = nsr;
            old_pos = m_pos;
            m_pos = dir ? (m_pos + W - 1) % W : (m_pos + 1) % W;
            m_wrap = (old_pos != 0) && (m_pos == 0);
        end else begin
            m_wrap = 1'b0;
        end
        sbq.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        load = 1'b0;
        en = 1'b0;
        m_sr = 13'h0001;
        m_pos = 0;
        m_wrap = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t a;
        exp_t e;
        do_reset();
        a = '{pat, pat_n, pos, wrap};
        e = '{13'h0001, 13'h1ffe, 4'd0, 1'b0};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL reset_state got pat=%h pat_n=%h pos=%0d wrap=%b want pat=%h pat_n=%h pos=%0d wrap=%b",
                     a.pat, a.pat_n, a.pos, a.wrap, e.pat, e.pat_n, e.pos, e.wrap);
        end
    endtask

    task automatic test_rotate_left();
        exp_t a;
        exp_t e;
        do_reset();
        mode = 1'b0;
        dir = 1'b0;
        en = 1'b1;
        for (int s = 1; s <= 14; s++) begin
            if (s == 14) en = 1'b0;
            cycle();
            a = '{pat, pat_n, pos, wrap};
            e = sbq.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL rot_left step %0d got pat=%h pos=%0d wrap=%b want pat=%h pos=%0d wrap=%b",
                         s, a.pat, a.pos, a.wrap, e.pat, e.pos, e.wrap);
            end
            if (s == 13) begin
                total++;
                if (pat !== 13'h0001 || pos !== 4'd0 || wrap !== 1'b1) begin
                    bad++;
                    $display("FAIL rot_left_wrap got pat=%h pos=%0d wrap=%b want pat=0001 pos=0 wrap=1",
                             pat, pos, wrap);
                end
            end
        end
    endtask

    task automatic test_rotate_right();
        exp_t a;
        exp_t e;
        do_reset();
        mode = 1'b0;
        dir = 1'b1;
        en = 1'b1;
        for (int s = 1; s <= 2; s++) begin
            cycle();
            a = '{pat, pat_n, pos, wrap};
            e = sbq.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL rot_right step %0d got pat=%h pos=%0d wrap=%b want pat=%h pos=%0d wrap=%b",
                         s, a.pat, a.pos, a.wrap, e.pat, e.pos, e.wrap);
            end
        end
        total++;
        if (pat !== 13'h0800 || pos !== 4'd11) begin
            bad++;
            $display("FAIL rot_right_two got pat=%h pos=%0d want pat=0800 pos=11", pat, pos);
        end
        en = 1'b0;
    endtask

    task automatic test_load_override();
        exp_t a;
        exp_t e;
        do_reset();
        mode = 1'b0;
        dir = 1'b0;
        en = 1'b1;
        for (int s = 0; s < 6; s++) begin
            if (s == 5) begin
                load = 1'b1;
                load_data = 13'h1abc;
            end
            cycle();
            a = '{pat, pat_n, pos, wrap};
            e = sbq.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL load_seq step %0d got pat=%h pos=%0d wrap=%b want pat=%h pos=%0d wrap=%b",
                         s, a.pat, a.pos, a.wrap, e.pat, e.pos, e.wrap);
            end
        end
        load = 1'b0;
        en = 1'b0;
        total++;
        if (pat !== 13'h1abc || pos !== 4'd0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_override got pat=%h pos=%0d wrap=%b want pat=1abc pos=0 wrap=0",
                     pat, pos, wrap);
        end
    endtask

    task automatic test_shift_fill();
        exp_t a;
        exp_t e;
        do_reset();
        mode = 1'b1;
        dir = 1'b0;
        en = 1'b1;
        for (int s = 1; s <= 26; s++) begin
            ser_in = (s <= 13);
            cycle();
            a = '{pat, pat_n, pos, wrap};
            e = sbq.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL shift step %0d got pat=%h pos=%0d wrap=%b want pat=%h pos=%0d wrap=%b",
                         s, a.pat, a.pos, a.wrap, e.pat, e.pos, e.wrap);
            end
            if (s == 13) begin
                total++;
                if (pat !== 13'h1fff || wrap !== 1'b1) begin
                    bad++;
                    $display("FAIL shift_ones got pat=%h wrap=%b want pat=1fff wrap=1", pat, wrap);
                end
            end
        end
        total++;
        if (pat !== 13'h0000) begin
            bad++;
            $display("FAIL shift_zeros got pat=%h want pat=0000", pat);
        end
        en = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_blank();
        exp_t a;
        exp_t e;
        do_reset();
        dir = 1'b0;
        en = 1'b1;
        disp_en = 1'b0;
        for (int s = 1; s <= 7; s++) begin
            if (s == 7) begin
                disp_en = 1'b1;
                en = 1'b0;
            end
            cycle();
            a = '{pat, pat_n, pos, wrap};
            e = sbq.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL blank step %0d got pat=%h pat_n=%h pos=%0d want pat=%h pat_n=%h pos=%0d",
                         s, a.pat, a.pat_n, a.pos, e.pat, e.pat_n, e.pos);
            end
        end
        total++;
        if (pat !== 13'h0040 || pat_n !== 13'h1fbf || pos !== 4'd6) begin
            bad++;
            $display("FAIL unblank got pat=%h pat_n=%h pos=%0d want pat=0040 pat_n=1fbf pos=6",
                     pat, pat_n, pos);
        end
    endtask

    task automatic test_async_reset();
        exp_t a;
        exp_t e;
        do_reset();
        dir = 1'b0;
        en = 1'b1;
        for (int s = 0; s < 7; s++) begin
            cycle();
            void'(sbq.pop_front());
        end
        en = 1'b0;
        #3;
        rst = 1'b1;
        m_sr = 13'h0001;
        m_pos = 0;
        m_wrap = 1'b0;
        #1;
        total++;
        if (pat !== 13'h0001 || pos !== 4'd0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got pat=%h pos=%0d wrap=%b want pat=0001 pos=0 wrap=0",
                     pat, pos, wrap);
        end
        #1;
        rst = 1'b0;
        en = 1'b1;
        cycle();
        a = '{pat, pat_n, pos, wrap};
        e = sbq.pop_front();
        total++;
        if (a !== e || pat !== 13'h0002) begin
            bad++;
            $display("FAIL after_reset got pat=%h pos=%0d want pat=%h pos=%0d",
                     a.pat, a.pos, e.pat, e.pos);
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t a;
        exp_t e;
        do_reset();
        for (int s = 0; s < 300; s++) begin
            en = ($urandom_range(0, 3) != 0);
            dir = 1'($urandom);
            mode = 1'($urandom);
            ser_in = 1'($urandom);
            disp_en = ($urandom_range(0, 4) != 0);
            load = ($urandom_range(0, 15) == 0);
            load_data = 13'($urandom);
            cycle();
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL random_queue_empty step %0d", s);
            end else begin
                a = '{pat, pat_n, pos, wrap};
                e = sbq.pop_front();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL random step %0d got pat=%h pat_n=%h pos=%0d wrap=%b want pat=%h pat_n=%h pos=%0d wrap=%b",
                             s, a.pat, a.pat_n, a.pos, a.wrap, e.pat, e.pat_n, e.pos, e.wrap);
                end
            end
        end
        load = 1'b0;
        en = 1'b0;
        disp_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_load_override();
        test_shift_fill();
        test_blank();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
